// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini-SRC control sequencer: state encoding, opcodes,
// ALU codes and control-word bit positions (also used by the ctrl[] wrapper).
package cpu_ctrl_pkg;

    localparam int OPW   = 5;
    localparam int CTRLW = 19;
    localparam int ALUW  = 5;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [ALUW-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALUW-1:0] ALU_ADD  = 5'b00011;
    localparam logic [ALUW-1:0] ALU_SUB  = 5'b00100;
    localparam logic [ALUW-1:0] ALU_AND  = 5'b00101;
    localparam logic [ALUW-1:0] ALU_OR   = 5'b00110;

    localparam int C_PCOUT  = 0;
    localparam int C_INCPC  = 1;
    localparam int C_MARIN  = 2;
    localparam int C_READ   = 3;
    localparam int C_WRITE  = 4;
    localparam int C_RAMEN  = 5;
    localparam int C_MDRIN  = 6;
    localparam int C_MDROUT = 7;
    localparam int C_IRIN   = 8;
    localparam int C_GRA    = 9;
    localparam int C_GRB    = 10;
    localparam int C_GRC    = 11;
    localparam int C_RIN    = 12;
    localparam int C_ROUT   = 13;
    localparam int C_BAOUT  = 14;
    localparam int C_COUT   = 15;
    localparam int C_YIN    = 16;
    localparam int C_ZLOIN  = 17;
    localparam int C_ZLOOUT = 18;

    // Instructions whose effective address is rB + C (ld, ldi, st).
    function automatic logic is_addr_op(input logic [OPW-1:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic is_rtype(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_imm(input logic [OPW-1:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic has_execute(input logic [OPW-1:0] op);
        return is_addr_op(op) || is_rtype(op) || is_imm(op);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode) into the control word and ALU code.
// Undefined opcodes never reach T3, but decode to all-zero there regardless.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t            state,
    input  logic [OPW-1:0]    opcode,
    output logic [CTRLW-1:0]  ctrl,
    output logic [ALUW-1:0]   alu_ctrl
);

    logic op_addr;
    logic op_r;
    logic op_i;

    assign op_addr = is_addr_op(opcode);
    assign op_r    = is_rtype(opcode);
    assign op_i    = is_imm(opcode);

    always_comb begin
        ctrl     = '0;
        alu_ctrl = ALU_NONE;
        case (state)
            ST_T0: begin
                ctrl[C_PCOUT] = 1'b1;
                ctrl[C_MARIN] = 1'b1;
                ctrl[C_INCPC] = 1'b1;
            end
            ST_T1: begin
                ctrl[C_READ]  = 1'b1;
                ctrl[C_RAMEN] = 1'b1;
                ctrl[C_MDRIN] = 1'b1;
            end
            ST_T2: begin
                ctrl[C_MDROUT] = 1'b1;
                ctrl[C_IRIN]   = 1'b1;
            end
            ST_T3: begin
                if (op_addr || op_r || op_i) begin
                    ctrl[C_GRB] = 1'b1;
                    ctrl[C_YIN] = 1'b1;
                end
                // Base-address forms read R0 as zero through BAout.
                if (op_addr)
                    ctrl[C_BAOUT] = 1'b1;
                if (op_r || op_i)
                    ctrl[C_ROUT] = 1'b1;
            end
            ST_T4: begin
                if (op_addr || op_i) begin
                    ctrl[C_COUT]  = 1'b1;
                    ctrl[C_ZLOIN] = 1'b1;
                end
                if (op_r) begin
                    ctrl[C_GRC]   = 1'b1;
                    ctrl[C_ROUT]  = 1'b1;
                    ctrl[C_ZLOIN] = 1'b1;
                    // R-type opcodes are numerically equal to their ALU codes.
                    alu_ctrl      = opcode;
                end
                if (op_addr || opcode == OP_ADDI)
                    alu_ctrl = ALU_ADD;
                else if (opcode == OP_ANDI)
                    alu_ctrl = ALU_AND;
                else if (opcode == OP_ORI)
                    alu_ctrl = ALU_OR;
            end
            ST_T5: begin
                if (opcode == OP_LD || opcode == OP_ST) begin
                    ctrl[C_ZLOOUT] = 1'b1;
                    ctrl[C_MARIN]  = 1'b1;
                end else if (op_addr || op_r || op_i) begin
                    ctrl[C_ZLOOUT] = 1'b1;
                    ctrl[C_GRA]    = 1'b1;
                    ctrl[C_RIN]    = 1'b1;
                end
            end
            ST_T6: begin
                if (opcode == OP_LD) begin
                    ctrl[C_READ]  = 1'b1;
                    ctrl[C_RAMEN] = 1'b1;
                    ctrl[C_MDRIN] = 1'b1;
                end else if (opcode == OP_ST) begin
                    ctrl[C_GRA]   = 1'b1;
                    ctrl[C_ROUT]  = 1'b1;
                    ctrl[C_MDRIN] = 1'b1;
                end
            end
            ST_T7: begin
                if (opcode == OP_LD) begin
                    ctrl[C_MDROUT] = 1'b1;
                    ctrl[C_GRA]    = 1'b1;
                    ctrl[C_RIN]    = 1'b1;
                end else if (opcode == OP_ST) begin
                    ctrl[C_WRITE] = 1'b1;
                    ctrl[C_RAMEN] = 1'b1;
                end
            end
            default: begin
                ctrl     = '0;
                alu_ctrl = ALU_NONE;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini-SRC datapath: state register and
// next-state logic. Define CTRL_MEM_WAIT_EN to add mem_ready stalling of RAM states.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       ir,
`ifdef CTRL_MEM_WAIT_EN
    input  logic              mem_ready,
`endif
    output logic [CTRLW-1:0]  ctrl,
    output logic [ALUW-1:0]   aluControl,
    output logic              run,
    output logic [3:0]        present_state
);

    state_t          state_q;
    state_t          state_d;
    logic [OPW-1:0]  opcode;
    logic            mem_hold;
    logic            unused_ir_fields;

    assign opcode           = ir[31:27];
    assign unused_ir_fields = ^ir[26:0];

    ctrl_decode u_decode (
        .state    (state_q),
        .opcode   (opcode),
        .ctrl     (ctrl),
        .alu_ctrl (aluControl)
    );

`ifdef CTRL_MEM_WAIT_EN
    // Any state driving a RAM access waits for the RAM, strobes held meanwhile.
    assign mem_hold = ~mem_ready & (ctrl[C_READ] | ctrl[C_WRITE]);
`else
    assign mem_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2: begin
                if (opcode == OP_HALT)
                    state_d = ST_HALT;
                else if (has_execute(opcode))
                    state_d = ST_T3;
                else
                    state_d = ST_T0;
            end
            ST_T3:    state_d = ST_T4;
            ST_T4:    state_d = ST_T5;
            ST_T5: begin
                if (opcode == OP_LD || opcode == OP_ST)
                    state_d = ST_T6;
                else
                    state_d = ST_T0;
            end
            ST_T6:    state_d = ST_T7;
            ST_T7:    state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
        if (mem_hold)
            state_d = state_q;
    end

    always_ff @(posedge clock) begin
        if (clear)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    assign run           = (state_q != ST_RESET) && (state_q != ST_HALT);
    assign present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a step-table model of each
// instruction class, directed cases and a randomized instruction stream.
module tb_control_sequencer;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] c;
        logic [4:0]  alu;
    } step_t;

    logic        clk;
    logic        clear;
    logic [31:0] ir;
    logic [18:0] ctrl;
    logic [4:0]  aluControl;
    logic        run;
    logic [3:0]  present_state;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif

    int checks = 0;
    int errors = 0;

    step_t       exp_q[$];
    logic [3:0]  exp_final;

    logic [4:0] def_ops [0:10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                   5'd12, 5'd13, 5'd14, 5'd26};

    control_sequencer dut (
        .clock         (clk),
        .clear         (clear),
        .ir            (ir),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .ctrl          (ctrl),
        .aluControl    (aluControl),
        .run           (run),
        .present_state (present_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] bm(input int a, input int b, input int c);
        logic [18:0] v;
        v = (19'd1 << a) | (19'd1 << b);
        if (c >= 0)
            v = v | (19'd1 << c);
        return v;
    endfunction

    function automatic step_t mk(input int st, input logic [18:0] c, input logic [4:0] alu);
        step_t s;
        s.st  = 4'(st);
        s.c   = c;
        s.alu = alu;
        return s;
    endfunction

    // Expected per-cycle behaviour of one instruction, straight from the step tables.
    function automatic void build_seq(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(mk(1, bm(0, 1, 2), 5'd0));
        exp_q.push_back(mk(2, bm(3, 5, 6), 5'd0));
        exp_q.push_back(mk(3, bm(7, 8, -1), 5'd0));
        exp_final = 4'd1;
        case (op)
            5'd0, 5'd1, 5'd2: begin
                exp_q.push_back(mk(4, bm(10, 14, 16), 5'd0));
                exp_q.push_back(mk(5, bm(15, 17, -1), 5'd3));
                if (op == 5'd1) begin
                    exp_q.push_back(mk(6, bm(9, 12, 18), 5'd0));
                end else begin
                    exp_q.push_back(mk(6, bm(18, 2, -1), 5'd0));
                    if (op == 5'd0) begin
                        exp_q.push_back(mk(7, bm(3, 5, 6), 5'd0));
                        exp_q.push_back(mk(8, bm(7, 9, 12), 5'd0));
                    end else begin
                        exp_q.push_back(mk(7, bm(9, 13, 6), 5'd0));
                        exp_q.push_back(mk(8, bm(4, 5, -1), 5'd0));
                    end
                end
            end
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(mk(4, bm(10, 13, 16), 5'd0));
                exp_q.push_back(mk(5, bm(11, 13, 17), op));
                exp_q.push_back(mk(6, bm(18, 9, 12), 5'd0));
            end
            5'd12, 5'd13, 5'd14: begin
                exp_q.push_back(mk(4, bm(10, 13, 16), 5'd0));
                exp_q.push_back(mk(5, bm(15, 17, -1),
                                   (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6));
                exp_q.push_back(mk(6, bm(18, 9, 12), 5'd0));
            end
            5'd27: exp_final = 4'd9;
            default: exp_final = 4'd1;
        endcase
    endfunction

    // Starts at a falling edge in T0; ends at a falling edge after the instruction.
    task automatic exec_instr(input logic [31:0] irv, input int wait_n, input string tag);
        int n;
        build_seq(irv[31:27]);
        ir = irv;
        foreach (exp_q[i]) begin
            n = 0;
`ifdef CTRL_MEM_WAIT_EN
            if (exp_q[i].c[3] || exp_q[i].c[4])
                n = (wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n;
`endif
            for (int k = 0; k <= n; k++) begin
`ifdef CTRL_MEM_WAIT_EN
                mem_ready = (k == n);
`endif
                checks++;
                if (present_state !== exp_q[i].st || ctrl !== exp_q[i].c ||
                    aluControl !== exp_q[i].alu || run !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ir=%08h step %0d cyc %0d: state=%0d ctrl=%05h alu=%05b run=%b, expected state=%0d ctrl=%05h alu=%05b run=1",
                             tag, irv, i, k, present_state, ctrl, aluControl, run,
                             exp_q[i].st, exp_q[i].c, exp_q[i].alu);
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        checks++;
        if (present_state !== exp_final) begin
            errors++;
            $display("FAIL %s ir=%08h end state: got %0d, expected %0d", tag, irv, present_state, exp_final);
        end
        $display("%s ir=%08h op=%05b cycles=%0d", tag, irv, irv[31:27], exp_q.size());
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd0 || ctrl !== 19'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d ctrl=%05h alu=%05b run=%b, expected 0 0 0 0",
                     present_state, ctrl, aluControl, run);
        end
        clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd1 || ctrl !== bm(0, 1, 2) || run !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state=%0d ctrl=%05h run=%b, expected state=1 ctrl=%05h run=1",
                     present_state, ctrl, run, bm(0, 1, 2));
        end
        $display("reset: state=%0d ctrl=%05h", present_state, ctrl);
    endtask

    task automatic test_directed();
        exec_instr(32'h08800095, 0, "ldi");
        exec_instr(32'h18900000, 0, "add");
        exec_instr(32'h10800010, 0, "st");
        exec_instr(32'h00800010, 0, "ld");
        exec_instr(32'hD0000000, 0, "nop");
        exec_instr(32'hF8000000, 0, "undef");
    endtask

    task automatic test_mem_wait();
        exec_instr(32'h08800095, 3, "memwait_ldi");
        exec_instr(32'h00800010, 2, "memwait_ld");
        exec_instr(32'h10800010, 1, "memwait_st");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [4:0]  op;
        for (int t = 0; t < 40; t++) begin
            r = $urandom();
            if ($urandom_range(0, 4) == 0)
                op = 5'($urandom_range(0, 31));
            else
                op = def_ops[$urandom_range(0, 10)];
            if (op == 5'd27)
                op = 5'd26;
            exec_instr({op, r[26:0]}, -1, "rand");
        end
    endtask

    task automatic test_clear_mid();
        ir = 32'h00800010;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (present_state !== 4'd7 || ctrl !== bm(3, 5, 6)) begin
            errors++;
            $display("FAIL clear_mid_t6: state=%0d ctrl=%05h, expected state=7 ctrl=%05h",
                     present_state, ctrl, bm(3, 5, 6));
        end
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b0;
`endif
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd0 || ctrl !== 19'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid: state=%0d ctrl=%05h alu=%05b run=%b, expected 0 0 0 0",
                     present_state, ctrl, aluControl, run);
        end
        clear = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd1) begin
            errors++;
            $display("FAIL clear_mid_release: state=%0d, expected 1", present_state);
        end
        $display("clear_mid: state=%0d", present_state);
    endtask

    task automatic test_halt();
        exec_instr(32'hD8000000, 0, "halt");
        for (int c = 0; c < 10; c++) begin
            ir = $urandom();
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (present_state !== 4'd9 || ctrl !== 19'd0 || aluControl !== 5'd0 || run !== 1'b0) begin
                errors++;
                $display("FAIL halt_idle cyc %0d: state=%0d ctrl=%05h alu=%05b run=%b, expected 9 0 0 0",
                         c, present_state, ctrl, aluControl, run);
            end
        end
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear: state=%0d run=%b, expected 0 0", present_state, run);
        end
        clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (present_state !== 4'd1) begin
            errors++;
            $display("FAIL halt_restart: state=%0d, expected 1", present_state);
        end
        $display("halt: idle 10 cycles, restart state=%0d", present_state);
    endtask

    initial begin
        clear = 1'b1;
        ir    = 32'd0;
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        test_reset();
        test_directed();
        test_mem_wait();
        test_back_to_back();
        test_clear_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
